// File: rtl/spi_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared state encoding and default widths for the SPI read
//               arbiter and its round-robin sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_ADDR_W = 16;
    localparam int SPI_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_BUSY  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Opcode the engine sends; kept here so requesters and engine agree.
    localparam logic [7:0] SPI_READ_COMMAND = 8'h03;

endpackage
`default_nettype wire

// File: rtl/spi_read_arbiter_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin grant. The grant is combinational; the
//               only state is the last granted port, updated when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic r_last_grant;

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~r_last_grant;
        end else begin
            grant_idx = req[1];
        end
    end

    // Resets to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (grant_en && grant_valid) begin
            r_last_grant <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_read_arbiter
// Description : Shares one SPI flash read engine between instruction fetch
//               (port 0) and data load (port 1), with a hang watchdog.
//               Optional one-entry read cache: define SPI_READ_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_read_arbiter
    import spi_pkg::*;
#(
    parameter int ADDR_W         = SPI_ADDR_W,
    parameter int DATA_W         = SPI_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              spi_ready,
    output logic [ADDR_W-1:0] spi_address,
    input  logic [DATA_W-1:0] spi_data,
    input  logic              spi_cs
);

    localparam int                c_WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_port;
    logic                r_err;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_WD_W-1:0]   w_wd_inc;
    logic                w_wd_expired;
    logic                w_abort;
    logic                w_capture;
    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;

    rr_arbiter2 u_arb (
        .clk         (sclk),
        .rst         (rst),
        .req         ({req1, req0}),
        .grant_en    (w_grant),
        .grant_valid (w_gnt_valid),
        .grant_idx   (w_gnt_idx)
    );

    assign w_grant      = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_gnt_addr   = w_gnt_idx ? addr1 : addr0;
    assign w_wd_inc     = r_wd + c_WD_W'(1);
    assign w_wd_expired = (w_wd_inc == c_WD_LIMIT);
    assign w_capture    = (r_state == ST_BUSY) && spi_cs;
    // A cs edge in the same cycle as expiry wins over the abort.
    assign w_abort      = (((r_state == ST_ISSUE) && spi_cs) ||
                           ((r_state == ST_BUSY) && !spi_cs)) && w_wd_expired;

`ifdef SPI_READ_CACHE_EN
    logic              r_cache_valid;
    logic [ADDR_W-1:0] r_cache_tag;
    logic [DATA_W-1:0] r_cache_data;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
            r_cache_data  <= '0;
        end else if (w_abort) begin
            r_cache_valid <= 1'b0;
        end else if (w_capture) begin
            r_cache_valid <= 1'b1;
            r_cache_tag   <= spi_address;
            r_cache_data  <= spi_data;
        end
    end

    assign w_hit      = r_cache_valid && (r_cache_tag == w_gnt_addr);
    assign w_hit_data = r_cache_data;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_next = w_hit ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!spi_cs) begin
                    w_state_next = ST_BUSY;
                end else if (w_wd_expired) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_BUSY: begin
                if (spi_cs || w_wd_expired) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        spi_ready = (r_state == ST_ISSUE);
        busy      = (r_state != ST_IDLE);
        ack0      = (r_state == ST_DONE) && !r_port;
        ack1      = (r_state == ST_DONE) && r_port;
        err       = (r_state == ST_DONE) && r_err;
    end

    // Datapath: address latch at grant, read capture, watchdog counter.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            spi_address <= '0;
            rdata       <= '0;
            r_port      <= 1'b0;
            r_err       <= 1'b0;
            r_wd        <= '0;
        end else begin
            if (w_state_next != r_state) begin
                r_wd <= '0;
            end else if ((r_state == ST_ISSUE) || (r_state == ST_BUSY)) begin
                r_wd <= w_wd_inc;
            end

            if (w_grant) begin
                spi_address <= w_gnt_addr;
                r_port      <= w_gnt_idx;
                r_err       <= 1'b0;
                if (w_hit) begin
                    rdata <= w_hit_data;
                end
            end

            if (w_capture) begin
                rdata <= spi_data;
            end

            if (w_abort) begin
                rdata <= '0;
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_read_arbiter
// Description : Self-checking bench for spi_read_arbiter with an SPI engine
//               model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_read_arbiter;

    localparam int LAT_MISS  = 37;
    localparam int LAT_HIT   = 2;
    localparam int LAT_ABORT = 66;
    localparam int ENG_LOW   = 33;
`ifdef SPI_READ_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [15:0] addr1 = '0;
    logic        ack0, ack1, err, busy, spi_ready;
    logic [15:0] spi_address;
    logic [7:0]  rdata;
    logic [7:0]  spi_data;
    logic        spi_cs;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: last granted port and the cache contents.
    bit          m_last = 1'b1;
    bit          m_cv = 1'b0;
    logic [15:0] m_ct = '0;
    logic [15:0] m_prev = '0;

    spi_read_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(64)) dut (
        .sclk(sclk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .ack1(ack1),
        .rdata(rdata), .err(err), .busy(busy),
        .spi_ready(spi_ready), .spi_address(spi_address),
        .spi_data(spi_data), .spi_cs(spi_cs)
    );

    always #5 sclk = ~sclk;

    function automatic logic [7:0] byte_of(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    // Engine model: starts on ready, holds cs low ENG_LOW cycles, data with cs rise.
    logic        eng_rst = 1'b1;
    logic        eng_stuck = 1'b0;
    logic        eng_active;
    int          eng_cnt;
    logic [15:0] eng_addr;
    always @(posedge sclk) begin
        if (eng_rst) begin
            spi_cs <= 1'b1; spi_data <= '0; eng_active <= 1'b0; eng_cnt <= 0; eng_addr <= '0;
        end else if (!eng_active) begin
            if (spi_ready && !eng_stuck) begin
                eng_active <= 1'b1; spi_cs <= 1'b0; eng_cnt <= 1; eng_addr <= spi_address;
            end
        end else if (eng_cnt == ENG_LOW) begin
            spi_cs <= 1'b1; spi_data <= byte_of(eng_addr); eng_active <= 1'b0;
        end else begin
            eng_cnt <= eng_cnt + 1;
        end
    end

    bit ready_seen = 1'b0;
    always @(negedge sclk) if (spi_ready) ready_seen = 1'b1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Waits for an ack; lat is the index of the ack cycle, the first negedge being first_n.
    task automatic wait_ack(input int first_n, input bit drop, output int port,
                            output int lat, output logic [7:0] d, output logic e);
        port = -1; lat = -1; d = 'x; e = 'x;
        for (int n = first_n; n < first_n + 200; n++) begin
            @(negedge sclk);
            if (ack0 || ack1) begin
                port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                lat = n; d = rdata; e = err;
                if (drop) begin
                    if (ack0) req0 = 1'b0;
                    if (ack1) req1 = 1'b0;
                end
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        m_last = 1'b1; m_cv = 1'b0; m_ct = '0;
    endtask

    function automatic int model_lat(input logic [15:0] a);
        return (CACHE_EN && m_cv && (m_ct == a)) ? LAT_HIT : LAT_MISS;
    endfunction

    // Serves one request or a simultaneous pair and checks against the model.
    task automatic serve(input string tag, input bit r0, input bit r1,
                         input logic [15:0] a0, input logic [15:0] a1);
        int first, port, lat;
        logic [7:0] d;
        logic e;
        logic [15:0] a;
        @(negedge sclk);
        addr0 = a0; addr1 = a1; req0 = r0; req1 = r1;
        first = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
        for (int k = 0; k < ((r0 && r1) ? 2 : 1); k++) begin
            a = (first == 1) ? a1 : a0;
            wait_ack((k == 0) ? 2 : 1, 1'b1, port, lat, d, e);
            chk({tag, " port"}, port, first);
            chk({tag, " latency"}, lat, model_lat(a));
            chk({tag, " rdata"}, d, byte_of(a));
            chk({tag, " err"}, e, 1'b0);
            m_last = first[0]; m_cv = 1'b1; m_ct = a; m_prev = a;
            first = 1 - first;
        end
    endtask

    typedef struct {
        bit          r0;
        bit          r1;
        logic [15:0] addr;
        int          port;
        logic [7:0]  data;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int port, lat;
        logic [7:0] d;
        logic e;
        int exp_ports[4];
        int ack_count;

        vecs[0] = '{1'b1, 1'b0, 16'h1234, 0, 8'hA5, 37};
        vecs[1] = '{1'b0, 1'b1, 16'hBEEF, 1, 8'hD2, 37};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 0, 8'h83, 37};
        vecs[3] = '{1'b0, 1'b1, 16'hFF00, 1, 8'h7C, 37};
        vecs[4] = '{1'b1, 1'b0, 16'h8001, 0, 8'h02, 37};

        // Reset state
        repeat (3) @(negedge sclk);
        eng_rst = 1'b0;
        chk("reset ack0", ack0, 0); chk("reset ack1", ack1, 0);
        chk("reset err", err, 0); chk("reset busy", busy, 0);
        chk("reset spi_ready", spi_ready, 0); chk("reset spi_address", spi_address, 0);
        chk("reset rdata", rdata, 0);
        rst = 1'b0;

        // Single reads from a table, including the 37-cycle nominal read
        foreach (vecs[i]) begin
            @(negedge sclk);
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            if (vecs[i].r0) addr0 = vecs[i].addr; else addr1 = vecs[i].addr;
            wait_ack(2, 1'b1, port, lat, d, e);
            chk("vec port", port, vecs[i].port);
            chk("vec latency", lat, vecs[i].lat);
            chk("vec rdata", d, vecs[i].data);
            chk("vec err", e, 0);
            chk("vec busy_at_ack", busy, 1);
            chk("vec spi_address", spi_address, vecs[i].addr);
            @(negedge sclk);
            chk("vec rdata_held", rdata, vecs[i].data);
            chk("vec idle_after", {busy, ack0, ack1}, 3'b000);
        end

        // Simultaneous requests after reset, held: strict 0,1,0,1
        do_reset();
        @(negedge sclk);
        addr0 = 16'h0010; addr1 = 16'h0020; req0 = 1'b1; req1 = 1'b1;
        exp_ports = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            wait_ack((k == 0) ? 2 : 1, 1'b0, port, lat, d, e);
            chk("alt port", port, exp_ports[k]);
            chk("alt rdata", d, exp_ports[k] ? 8'hA3 : 8'h93);
            chk("alt latency", lat, 37);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Watchdog abort with cs stuck high, then a normal read
        eng_stuck = 1'b1;
        @(negedge sclk);
        addr0 = 16'h4444; req0 = 1'b1;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("timeout port", port, 0);
        chk("timeout latency", lat, LAT_ABORT);
        chk("timeout err", e, 1);
        chk("timeout rdata", d, 8'h00);
        eng_stuck = 1'b0;
        @(negedge sclk);
        addr0 = 16'h1234; req0 = 1'b1;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("post_timeout port", port, 0);
        chk("post_timeout rdata", d, 8'hA5);
        chk("post_timeout err", e, 0);
        chk("post_timeout latency", lat, 37);

        // Asynchronous reset ten cycles into BUSY
        @(negedge sclk);
        addr1 = 16'h2222; req1 = 1'b1;
        for (int n = 0; n < 10 && spi_cs; n++) @(negedge sclk);
        chk("rst_mid engine_started", spi_cs, 0);
        repeat (10) @(negedge sclk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid outputs", {ack0, ack1, err, busy, spi_ready}, 5'b0);
        chk("rst_mid spi_address", spi_address, 0);
        chk("rst_mid rdata", rdata, 0);
        @(negedge sclk);
        req1 = 1'b0;
        @(negedge sclk);
        rst = 1'b0;
        m_last = 1'b1; m_cv = 1'b0;
        ack_count = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge sclk);
            if (ack0 || ack1) ack_count++;
        end
        chk("rst_mid no_ack", ack_count, 0);
        @(negedge sclk);
        addr1 = 16'h3355; req1 = 1'b1;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("post_rst port", port, 1);
        chk("post_rst rdata", d, 8'hE5);
        chk("post_rst latency", lat, 37);

`ifdef SPI_READ_CACHE_EN
        // Cache: miss, hit without engine activity, then a neighbouring miss
        do_reset();
        @(negedge sclk);
        addr0 = 16'h0100; req0 = 1'b1;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("cache miss latency", lat, 37);
        chk("cache miss rdata", d, 8'h82);
        @(negedge sclk);
        addr0 = 16'h0100; req0 = 1'b1; ready_seen = 1'b0;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("cache hit latency", lat, LAT_HIT);
        chk("cache hit rdata", d, 8'h82);
        chk("cache hit no_ready", ready_seen, 0);
        @(negedge sclk);
        addr0 = 16'h0101; req0 = 1'b1;
        wait_ack(2, 1'b1, port, lat, d, e);
        chk("cache miss2 latency", lat, 37);
        chk("cache miss2 rdata", d, 8'h83);
`endif

        // req1 held through its ack re-requests with a freshly latched address
        @(negedge sclk);
        addr1 = 16'h0A1B; req1 = 1'b1;
        wait_ack(2, 1'b0, port, lat, d, e);
        chk("hold first port", port, 1);
        chk("hold first rdata", d, 8'h92);
        addr1 = 16'h0C3D;
        repeat (2) @(negedge sclk);
        chk("hold relatch spi_address", spi_address, 16'h0C3D);
        chk("hold relatch busy", busy, 1);
        wait_ack(3, 1'b1, port, lat, d, e);
        chk("hold second port", port, 1);
        chk("hold second rdata", d, 8'hB2);
        chk("hold second latency", lat, 37);

        // Randomized traffic against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int pat;
            logic [15:0] ra0, ra1;
            pat = $urandom_range(1, 3);
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra0 = m_prev;
            if ($urandom_range(0, 3) == 0) ra1 = m_prev;
            serve("rand", pat[0], pat[1], ra0, ra1);
            repeat ($urandom_range(0, 3)) @(negedge sclk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
